// File: rtl/sbio_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sbio_tx_arbiter
// Purpose  : Fixed-priority arbiter and framer for a narrow serial link.
//            Three sources (scan, out, read) compete for the link. The winner's
//            word is serialised as one frame:
//              START (pattern 1) -> HDR (source id) -> PAYLOAD_CYCLES symbols,
//            LSB first. Frames can run back to back with no idle gap.
//            Priority is read > out > scan. A read may optionally be held off
//            while too many read frames are still waiting for their response.
// Optional : SBIO_TX_READ_LIMIT_EN - when defined, the outstanding-read
//            counter and read-eligibility limit are built. When undefined, a
//            read is always eligible, rd_rsp_done is ignored and outstanding
//            reads as 0.
// Ports    :
//   clk          in   1            rising-edge clock
//   reset        in   1            asynchronous, active-high reset
//   req_valid    in   3            per-source request (0 scan, 1 out, 2 read)
//   req_data     in   3*WORD_SIZE  per-source payload, source i at [i*WORD_SIZE +: WORD_SIZE]
//   req_ready    out  3            one-hot grant, combinational
//   rd_rsp_done  in   1            one pulse per read response received
//   tx_pins      out  IO_BITS      registered serial symbol
//   busy         out  1            high while a frame is being sent
//   outstanding  out  3            unanswered read frames
// Revision : 1.0 - initial release
// ============================================================================
module sbio_tx_arbiter #(
  parameter int IO_BITS         = 2,
  parameter int PAYLOAD_CYCLES  = 8,
  parameter int MAX_OUTSTANDING = 3,
  localparam int WORD_SIZE      = PAYLOAD_CYCLES * IO_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             req_valid,
  input  logic [3*WORD_SIZE-1:0] req_data,
  output logic [2:0]             req_ready,
  input  logic                   rd_rsp_done,
  output logic [IO_BITS-1:0]     tx_pins,
  output logic                   busy,
  output logic [2:0]             outstanding
);

  localparam int                CNT_W     = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PAYLOAD_CYCLES - 1);
  localparam logic [2:0]        MAX_OUT_W = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_HDR   = 2'd2,
    ST_PAY   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state_q,       state_d;
  logic [IO_BITS-1:0]   tx_pins_q,     tx_pins_d;
  logic                 busy_q,        busy_d;
  logic [WORD_SIZE-1:0] shift_q,       shift_d;
  logic [1:0]           hdr_q,         hdr_d;
  logic [CNT_W-1:0]     cnt_q,         cnt_d;
  logic                 armed_q,       armed_d;
  logic [2:0]           outstanding_q, outstanding_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic                 grant_window;
  logic                 rd_eligible;
  logic                 win_valid;
  logic [1:0]           win_idx;
  logic [WORD_SIZE-1:0] win_data;
  logic                 grant;

  // armed_q stays low for the first cycle after reset release, so the
  // earliest grant is in the second cycle.
  assign grant_window = armed_q &&
                        ((state_q == ST_IDLE) ||
                         ((state_q == ST_PAY) && (cnt_q == LAST_CNT)));

`ifdef SBIO_TX_READ_LIMIT_EN
  assign rd_eligible = (outstanding_q < MAX_OUT_W);
`else
  assign rd_eligible = 1'b1;
`endif

  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    if (req_valid[2] && rd_eligible) begin
      win_valid = 1'b1;
      win_idx   = 2'd2;
    end else if (req_valid[1]) begin
      win_valid = 1'b1;
      win_idx   = 2'd1;
    end else if (req_valid[0]) begin
      win_valid = 1'b1;
      win_idx   = 2'd0;
    end
  end

  always_comb begin
    win_data = req_data[0 +: WORD_SIZE];
    case (win_idx)
      2'd1:    win_data = req_data[WORD_SIZE +: WORD_SIZE];
      2'd2:    win_data = req_data[2*WORD_SIZE +: WORD_SIZE];
      default: win_data = req_data[0 +: WORD_SIZE];
    endcase
  end

  always_comb begin
    req_ready = 3'b000;
    if (grant_window && win_valid) begin
      req_ready = 3'b001 << win_idx;
    end
  end

  assign grant = |req_ready;

  // --------------------------------------------------------------------------
  // Framer next state. tx_pins is registered, so every branch computes the
  // symbol that appears on the pins in the following cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tx_pins_d = tx_pins_q;
    busy_d    = busy_q;
    shift_d   = shift_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    armed_d   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_pins_d = '0;
        busy_d    = 1'b0;
      end
      ST_START: begin
        state_d   = ST_HDR;
        tx_pins_d = IO_BITS'(hdr_q);
      end
      ST_HDR: begin
        state_d   = ST_PAY;
        cnt_d     = '0;
        tx_pins_d = shift_q[IO_BITS-1:0];
        shift_d   = shift_q >> IO_BITS;
      end
      ST_PAY: begin
        if (cnt_q == LAST_CNT) begin
          state_d   = ST_IDLE;
          tx_pins_d = '0;
          busy_d    = 1'b0;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          tx_pins_d = shift_q[IO_BITS-1:0];
          shift_d   = shift_q >> IO_BITS;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tx_pins_d = '0;
        busy_d    = 1'b0;
      end
    endcase

    // A grant can only happen in IDLE or the last payload cycle; it starts
    // the next frame immediately and captures the winner's word.
    if (grant) begin
      state_d   = ST_START;
      tx_pins_d = IO_BITS'(1);
      busy_d    = 1'b1;
      hdr_d     = win_idx;
      shift_d   = win_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding read counter
  // --------------------------------------------------------------------------
`ifdef SBIO_TX_READ_LIMIT_EN
  always_comb begin
    outstanding_d = outstanding_q;
    // A grant and a response in the same cycle cancel out.
    if (req_ready[2] && !rd_rsp_done) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!req_ready[2] && rd_rsp_done && (outstanding_q != 3'd0)) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{rd_rsp_done, MAX_OUT_W};

  always_comb begin
    outstanding_d = 3'd0;
  end
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tx_pins_q     <= '0;
      busy_q        <= 1'b0;
      shift_q       <= '0;
      hdr_q         <= 2'd0;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      outstanding_q <= 3'd0;
    end else begin
      state_q       <= state_d;
      tx_pins_q     <= tx_pins_d;
      busy_q        <= busy_d;
      shift_q       <= shift_d;
      hdr_q         <= hdr_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign tx_pins     = tx_pins_q;
  assign busy        = busy_q;
  assign outstanding = outstanding_q;

endmodule

`default_nettype wire
